// File: rtl/mux_pkg.sv
// Shared definitions for the N-way registered multiplexer.
package mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Occupancy of the one-entry output register.
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Next channel index after idx, wrapping from n-1 back to 0.
   function automatic int unsigned chan_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter
#(
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
)
(
   input  logic [CHANNELS-1:0] req,
   input  logic [SEL_W-1:0]    ptr,
   output logic [CHANNELS-1:0] grant,
   output logic [SEL_W-1:0]    grant_idx,
   output logic                grant_any
);

   // Scan ptr, ptr+1, ... with wrap-around; the first active request is granted.
   always_comb begin
      int               c;
      logic [SEL_W-1:0] cidx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      c         = 0;
      cidx      = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         c = int'(ptr) + k;
         if (c >= CHANNELS) c = c - CHANNELS;
         cidx = SEL_W'(c);
         if (!grant_any && req[cidx]) begin
            grant[cidx] = 1'b1;
            grant_idx   = cidx;
            grant_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_nway_rr.sv
// Registered N-way multiplexer with fixed-select or round-robin arbitration
// and valid/ready handshakes on every input and on the output.
module mux_nway_rr
   import mux_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = $clog2(CHANNELS)
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   out_state_t            state_p1, state_nxt;
   logic [WIDTH-1:0]      data_p1;
   logic [SEL_W-1:0]      chan_p1;
   logic [SEL_W-1:0]      rr_ptr;

   logic [CHANNELS-1:0]   rr_oh;
   logic [SEL_W-1:0]      rr_idx;
   logic                  rr_any;
   logic [CHANNELS-1:0]   fx_oh;
   logic [CHANNELS-1:0]   grant_oh;
   logic [SEL_W-1:0]      grant_idx;
   logic                  grant_any;
   logic                  vld_p1;
   logic                  can_load;
   logic                  load;
   logic [WIDTH-1:0]      sel_word;

   rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .grant     (rr_oh),
      .grant_idx (rr_idx),
      .grant_any (rr_any)
   );

   // Fixed-mode eligibility; an out-of-range sel matches no channel, so nothing is granted.
   always_comb begin
      fx_oh = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SEL_W'(i) && in_valid[i]) fx_oh[i] = 1'b1;
      end
   end

   assign grant_oh  = (mode == MODE_RR) ? rr_oh  : fx_oh;
   assign grant_idx = (mode == MODE_RR) ? rr_idx : sel;
   assign grant_any = (mode == MODE_RR) ? rr_any : (|fx_oh);

   assign vld_p1   = (state_p1 == OUT_FULL);
   assign can_load = !vld_p1 || out_ready;
   assign load     = can_load && grant_any;
   assign in_ready = (load && !rst) ? grant_oh : '0;

   // One-hot data select keeps unused channel slices out of the index path.
   always_comb begin
      sel_word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant_oh[i]) sel_word = sel_word | in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output register occupancy: refill on pass-through, drain when nothing is granted.
   always_comb begin
      state_nxt = state_p1;
      if (can_load) begin
         state_nxt = grant_any ? OUT_FULL : OUT_EMPTY;
      end
   end

   // ---- stage p1: output register and round-robin pointer ----
   // Capture the granted word and advance the pointer past a round-robin winner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_p1 <= OUT_EMPTY;
         data_p1  <= '0;
         chan_p1  <= '0;
         rr_ptr   <= '0;
      end else begin
         state_p1 <= state_nxt;
         if (load) begin
            data_p1 <= sel_word;
            chan_p1 <= grant_idx;
            if (mode == MODE_RR) begin
               rr_ptr <= SEL_W'(chan_inc(32'(grant_idx), CHANNELS));
            end
         end
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_chan  = chan_p1;

endmodule

// File: tb/tb_mux_nway_rr.sv
// Directed bench for mux_nway_rr with a cycle-level reference model.
module tb_mux_nway_rr;

   localparam int WIDTH    = 16;
   localparam int CHANNELS = 4;
   localparam int SEL_W    = 2;

   logic                      clk;
   logic                      rst;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_chan;
   logic                      out_valid;
   logic                      out_ready;

   logic [WIDTH-1:0] ch_data [CHANNELS];

   int n_checks = 0;
   int n_fail   = 0;

   mux_nway_rr #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < CHANNELS; i++) in_data[i*WIDTH +: WIDTH] = ch_data[i];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the output register as plain variables, updated per clock.
   logic             m_valid, n_valid;
   logic [WIDTH-1:0] m_data, n_data;
   int               m_chan, n_chan;
   int               m_ptr, n_ptr;

   initial begin
      int  g;
      bit  g_any;
      logic [CHANNELS-1:0] exp_ready;
      m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
      forever begin
         @(negedge clk);
         n_valid = m_valid; n_data = m_data; n_chan = m_chan; n_ptr = m_ptr;
         if (rst) begin
            check("mdl_rst_valid", 32'(out_valid), 32'd0);
            check("mdl_rst_data", 32'(out_data), 32'd0);
            check("mdl_rst_ready", 32'(in_ready), 32'd0);
         end else begin
            g = 0; g_any = 0;
            if (mode == 1'b0) begin
               if (int'(sel) < CHANNELS && in_valid[sel]) begin g = int'(sel); g_any = 1; end
            end else begin
               for (int k = 0; k < CHANNELS; k++) begin
                  if (!g_any && in_valid[(m_ptr + k) % CHANNELS]) begin
                     g = (m_ptr + k) % CHANNELS; g_any = 1;
                  end
               end
            end
            exp_ready = '0;
            if (g_any && (!m_valid || out_ready)) exp_ready[g] = 1'b1;
            check("mdl_in_ready", 32'(in_ready), 32'(exp_ready));
            check("mdl_out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
               check("mdl_out_data", 32'(out_data), 32'(m_data));
               check("mdl_out_chan", 32'(out_chan), 32'(m_chan));
            end
            if (exp_ready != '0) begin
               n_valid = 1; n_data = ch_data[g]; n_chan = g;
               if (mode) n_ptr = (g + 1) % CHANNELS;
            end else if (out_ready) begin
               n_valid = 0;
            end
         end
         @(posedge clk);
         if (rst) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
         end else begin
            m_valid = n_valid; m_data = n_data; m_chan = n_chan; m_ptr = n_ptr;
         end
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      logic [WIDTH-1:0] rr_words [4];
      rr_words = '{16'h0000, 16'h1111, 16'h2222, 16'h3333};
      rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
      for (int i = 0; i < CHANNELS; i++) ch_data[i] = '0;
      tick();
      tick();
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_chan", 32'(out_chan), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;

      // Fixed mode
      ch_data[0] = 16'h0C00; ch_data[1] = 16'h0C01; ch_data[2] = 16'hA5A5; ch_data[3] = 16'h0C03;
      mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
      #1 check("fixed_ready_sel2", 32'(in_ready), 32'b0100);
      tick();
      check("fixed_data_sel2", 32'(out_data), 32'hA5A5);
      check("fixed_chan_sel2", 32'(out_chan), 32'd2);
      check("fixed_valid_sel2", 32'(out_valid), 32'd1);
      sel = 2'd3;
      #1 check("fixed_ready_sel3", 32'(in_ready), 32'b1000);
      tick();
      check("fixed_data_sel3", 32'(out_data), 32'h0C03);
      check("fixed_chan_sel3", 32'(out_chan), 32'd3);
      in_valid = 4'b0000;
      tick();
      check("fixed_drain_valid", 32'(out_valid), 32'd0);

      // Round-robin fairness from pointer 0
      for (int i = 0; i < CHANNELS; i++) ch_data[i] = rr_words[i];
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rr_chan", 32'(out_chan), 32'(k % 4));
         check("rr_data", 32'(out_data), 32'(rr_words[k % 4]));
         check("rr_valid", 32'(out_valid), 32'd1);
      end

      // Back-pressure holding ch1's word
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
         check("bp_hold_data", 32'(out_data), 32'h1111);
         check("bp_hold_chan", 32'(out_chan), 32'd1);
      end
      out_ready = 1'b1;
      #1 check("bp_release_ready", 32'(in_ready), 32'b0100);
      tick();
      check("bp_release_data", 32'(out_data), 32'h2222);
      check("bp_release_valid", 32'(out_valid), 32'd1);

      // Sparse request with pointer at 3: wraps to ch1, pointer becomes 2
      in_valid = 4'b0010;
      #1 check("sparse_ready", 32'(in_ready), 32'b0010);
      tick();
      check("sparse_chan", 32'(out_chan), 32'd1);
      check("sparse_data", 32'(out_data), 32'h1111);
      in_valid = 4'b1111;
      #1 check("sparse_ptr_after", 32'(in_ready), 32'b0100);

      // Fixed mode with the selected channel idle
      mode = 1'b0; sel = 2'd1; in_valid = 4'b1101;
      #1 check("fixed_idle_ready", 32'(in_ready), 32'd0);
      tick();
      check("fixed_idle_valid", 32'(out_valid), 32'd0);
      tick();
      check("fixed_idle_valid2", 32'(out_valid), 32'd0);

      // Reset asserted while a word is held
      mode = 1'b1; in_valid = 4'b1111;
      tick();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      rst = 1'b1;
      #1 check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_data", 32'(out_data), 32'd0);
      check("midrst_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      #1 check("postrst_ready", 32'(in_ready), 32'b0001);
      tick();
      check("postrst_chan", 32'(out_chan), 32'd0);
      check("postrst_data", 32'(out_data), 32'h0000);
      check("postrst_valid", 32'(out_valid), 32'd1);
      in_valid = '0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nway_rr.md
Name: mux_nway_rr

Overview:
- Parametrised, registered N-way data multiplexer; successor to the 16-bit 2:1 and 4-way multiplexers.
- Selects one of CHANNELS input words of WIDTH bits, in one of two modes:
  - fixed mode: the select port chooses the channel;
  - round-robin mode: the block arbitrates fairly among valid inputs.
- Every input and the output use a valid/ready handshake.
- The output is a one-entry register, so the block can sit between datapath stages of the CPU/memory fabric.

Parameters:
- WIDTH, 16, data bits per channel and on the output.
- CHANNELS, 4, number of input channels (at least 2; need not be a power of two).
- SEL_W, $clog2(CHANNELS), width of the select and channel-index fields (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- in_data  in  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready; one-hot or zero.
- out_data  out  WIDTH  registered selected word.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts the word.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
  - in_ready is forced to all-zero while rst=1.
- Output register has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - load = (!out_valid || out_ready) && grant_any.
  - FULL with out_ready=0: out_data and out_chan are held stable; no input is accepted.
  - FULL with out_ready=1 and grant_any=1: pass-through in the same cycle. The old word leaves, the new word loads, and out_valid stays 1.
  - FULL with out_ready=1 and grant_any=0: next state is EMPTY.
- Eligibility:
  - Fixed mode: grant = sel when in_valid[sel]=1 and sel<CHANNELS. If sel>=CHANNELS, there is no grant and the block never hangs.
  - Round-robin mode: grant = the first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo CHANNELS (wrap-around).
- in_ready[i] = (i==grant) && grant_any && (!out_valid || out_ready). This is combinational from in_valid, sel, mode, out_valid and out_ready. in_ready never depends on in_data.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. The word appears on out_data one cycle later with out_chan=i (latency 1).
- rr_ptr update:
  - Advances to (grant+1) mod CHANNELS only on a round-robin-mode transfer. Wrap from CHANNELS-1 goes to 0.
  - Unchanged in fixed mode and on cycles with no transfer.
- Mode or sel changes take effect on the same cycle's arbitration. A word already held in the output register is unaffected.
- A requester that drops in_valid before it is granted loses its turn without side effects.
- Reset asserted mid-transfer: the held word is discarded immediately (out_valid=0). After deassertion, arbitration restarts from channel 0.
- Throughput: one word per cycle when out_ready is held at 1.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - a localparam function for the modular increment of the channel index.
- Sub-module rr_arbiter (parameter CHANNELS):
  - inputs: req, ptr;
  - outputs: one-hot grant, grant index, grant_any.
  - Purely combinational. The rr_ptr register stays in mux_nway_rr.

Test Plan (WIDTH=16, CHANNELS=4):
- Reset: assert rst mid-run with out_valid=1 -> out_valid=0 and out_data=16'h0000 before the next clock edge; in_ready=4'b0000 while rst=1.
- Fixed mode: mode=0, sel=2, in_data ch2=16'hA5A5, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100; next cycle out_data=16'hA5A5, out_chan=2; sel=3 then selects ch3 on the following cycle.
- Round-robin fairness: mode=1, all four channels valid with data 16'h0000/16'h1111/16'h2222/16'h3333, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1 (wrap-around), one word per cycle.
- Back-pressure: out_valid=1 with out_data=16'h1111, out_ready=0 for 3 cycles -> out_data stays 16'h1111 and in_ready=4'b0000; on the cycle out_ready returns to 1, the next granted word loads with no gap.
- Sparse requests: mode=1, rr_ptr=3, only ch1 valid -> ch1 is granted (search wraps past ch3 and ch0) and rr_ptr becomes 2.
- Fixed mode edge cases: in_valid[sel]=0 -> no transfer, and out_valid falls to 0 after the held word drains.
